// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mul_pkg;

  localparam int unsigned MUL_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Shift-and-add datapath: mcand, accumulator, multiplier shift register and sign fix-up.
// Optional two's-complement operands when MUL_SIGNED_EN is defined.
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result
);

  logic [WIDTH:0]     acc_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_nx;
  logic [WIDTH-1:0]   q_nx;
  logic [2*WIDTH-1:0] raw;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;

`ifdef MUL_SIGNED_EN
  logic neg_q;

  // Magnitudes; the most negative value maps onto 2^(WIDTH-1), which still fits unsigned.
  assign op_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign op_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
`else
  assign op_a = a;
  assign op_b = b;
`endif

  always_comb begin
    sum    = q_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
    acc_nx = {1'b0, sum[WIDTH:1]};
    q_nx   = {sum[0], q_q[WIDTH-1:1]};
    raw    = {acc_nx[WIDTH-1:0], q_nx};
`ifdef MUL_SIGNED_EN
    result = neg_q ? (~raw + (2*WIDTH)'(1)) : raw;
`else
    result = raw;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      q_q     <= '0;
      mcand_q <= '0;
`ifdef MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else if (load) begin
      acc_q   <= '0;
      q_q     <= op_b;
      mcand_q <= op_a;
`ifdef MUL_SIGNED_EN
      neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
    end else if (step) begin
      acc_q <= acc_nx;
      q_q   <= q_nx;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential multiplier top: control FSM, iteration counter, result register and handshake.
// Define MUL_SIGNED_EN for two's-complement operands.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  mul_state_t         state_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] result;
  logic               load;
  logic               step;
  logic               last_iter;

  assign load      = (state_q == StIdle) && start;
  assign step      = (state_q == StRun);
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

  mul_shift_add #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .a      (a),
    .b      (b),
    .result (result)
  );

  // The result register only moves on RUN->DONE, so partial sums are never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      prod_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state_q <= StRun;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StRun: begin
          cnt_q <= cnt_q + CntW'(1);
          if (last_iter) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            prod_q  <= result;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign product_hi = prod_q[2*WIDTH-1:WIDTH];
  assign product_lo = prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: expected products queued at start, checked on done.
module tb_seq_multiplier;

  localparam int unsigned W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;

  seq_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2*W-1:0] sb[$];
  int             n_vec = 0;
  int             n_err = 0;
  int             done_cnt = 0;
  int unsigned    acc_cyc = 0;
  int unsigned    prev_acc = 0;
  bit             have_prev = 1'b0;
  bit             b2b_mode = 1'b0;
  logic [2*W-1:0] last_prod = '0;
  logic           prev_busy = 1'b0;
  logic           prev_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MUL_SIGNED_EN
    logic signed [2*W-1:0] sx, sy;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    return sx * sy;
`else
    logic [2*W-1:0] ux, uy;
    ux = {{W{1'b0}}, x};
    uy = {{W{1'b0}}, y};
    return ux * uy;
`endif
  endfunction

  // Output monitor: accept detection, hold, latency, done width and scoreboard pops.
  always @(negedge clk) begin
    logic [2*W-1:0] exp;
    if (!rst_n) begin
      last_prod = '0;
      prev_busy = 1'b0;
      prev_done = 1'b0;
      have_prev = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        acc_cyc = cyc;
        if (b2b_mode) begin
          if (have_prev) check("b2b_gap", 64'(acc_cyc - prev_acc), 64'(W + 2));
          prev_acc  = acc_cyc;
          have_prev = 1'b1;
        end else begin
          have_prev = 1'b0;
        end
      end
      if (busy) check("hold", {product_hi, product_lo}, last_prod);
      if (prev_done) check("done_width", 64'(done), 64'(0));
      if (done) begin
        done_cnt++;
        check("latency", 64'(cyc - acc_cyc), 64'(W));
        check("done_busy", 64'(busy), 64'(0));
        if (sb.size() == 0) begin
          check("spurious_done", 64'(done), 64'(0));
        end else begin
          exp = sb.pop_front();
          check("product", {product_hi, product_lo}, exp);
          last_prod = exp;
        end
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  // Issue one start pulse; returns at the negedge after the accept edge.
  task automatic start_mul(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    if (push) sb.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy && !done) break;
    end
    if (k == 200) check("idle_timeout", 64'({busy, done}), 64'(0));
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 100) check("done_timeout", 64'(done), 64'(1));
  endtask

  initial begin
    int dc;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_product", {product_hi, product_lo}, 64'(0));
    rst_n = 1'b1;

    // Reset mid-RUN discards the operation.
    start_mul(32'd7, 32'd9, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_product", {product_hi, product_lo}, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_mul(32'd3, 32'd5, 1'b1);
    wait_idle();

    // Basic; operands scrambled right after accept.
    start_mul(32'h0000_0006, 32'h0000_0007, 1'b1);
    a = 32'hDEAD_BEEF;
    b = 32'hCAFE_F00D;
    wait_idle();

    // Zero operand, prior result held, mid-run start ignored, one done.
    dc = done_cnt;
    start_mul(32'h0, 32'h1234_5678, 1'b1);
    repeat (5) @(negedge clk);
    a     = 32'd5;
    b     = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_requeue", 64'(busy), 64'(0));
    end
    check("done_once", 64'(done_cnt - dc), 64'(1));

    start_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_idle();

    for (int i = 0; i < 4; i++) begin
      start_mul(W'($urandom), W'($urandom), 1'b1);
      wait_idle();
    end

`ifdef MUL_SIGNED_EN
    start_mul(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_idle();
    start_mul(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_idle();
`endif

    // start held high: accepts every W+2 cycles, new operands loaded at each done.
    b2b_mode = 1'b1;
    @(negedge clk);
    a     = 32'h0001_2345;
    b     = 32'h0000_ABCD;
    start = 1'b1;
    sb.push_back(model(a, b));
    for (int k = 0; k < 3; k++) begin
      wait_done();
      if (k < 2) begin
        a = W'($urandom);
        b = W'($urandom);
        sb.push_back(model(a, b));
      end else begin
        start = 1'b0;
      end
    end
    wait_idle();
    b2b_mode = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
